// File: rtl/alu_muldiv_unit.sv
// EX-stage ALU with iterative RV32M/RV64M multiply/divide.
// Base ops return one cycle after accept; M ops hold in_ready low while iterating.
module alu_muldiv_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  output logic [XLEN-1:0] r,
  output logic            cf,
  output logic            zf,
  output logic            vf,
  output logic            sf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [SHW-1:0] LAST_ITER = SHW'(XLEN-1);

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  logic [1:0]        state;
  logic [SHW-1:0]    cnt;
  logic [4:0]        op_q;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic              neg_q;
  logic              neg_r;
  logic              accept;

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid && in_ready && !flush;

  // Base datapath: shared adder, shifter and logic unit
  logic              sub;
  logic [XLEN-1:0]   b_eff;
  logic [XLEN:0]     sum_ext;
  logic [XLEN-1:0]   sum;
  logic              carry;
  logic              ovf;
  logic              uses_adder;
  logic [SHW-1:0]    shamt;
  logic signed [XLEN-1:0] a_s;
  logic [XLEN-1:0]   base_r;

  always_comb begin
    sub     = (op[3:0] != 4'b0000);
    b_eff   = sub ? ~b : b;
    sum_ext = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub};
    sum     = sum_ext[XLEN-1:0];
    carry   = sum_ext[XLEN];
    ovf     = a[XLEN-1] ^ b_eff[XLEN-1] ^ sum[XLEN-1] ^ carry;
    shamt   = b[SHW-1:0];
    a_s     = $signed(a);
    uses_adder = (op == 5'b00000) || (op == 5'b00001) ||
                 (op == 5'b01101) || (op == 5'b01111);
    base_r  = '0;
    case (op)
      5'b00000, 5'b00001: base_r = sum;
      5'b00011:           base_r = b;
      5'b00100:           base_r = a | b;
      5'b00101:           base_r = a & b;
      5'b00111:           base_r = a ^ b;
      5'b01000:           base_r = a << shamt;
      5'b01001:           base_r = a >> shamt;
      5'b01010:           base_r = a_s >>> shamt;
      5'b01101:           base_r = {{(XLEN-1){1'b0}}, sum[XLEN-1] != ovf};
      5'b01111:           base_r = {{(XLEN-1){1'b0}}, ~carry};
      default:            base_r = '0;
    endcase
  end

  // M-op operand decode: signedness per op, magnitudes, fast-path detection
  logic            is_m;
  logic            is_div;
  logic            a_sgn;
  logic            b_sgn;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;

  always_comb begin
    is_m     = (op[4:3] == 2'b10);
    is_div   = op[2];
    a_sgn    = is_div ? !op[0] : (op[1:0] != 2'b11);
    b_sgn    = is_div ? !op[0] : !op[1];
    sa       = a_sgn && a[XLEN-1];
    sb       = b_sgn && b[XLEN-1];
    a_mag    = cond_neg(a, sa);
    b_mag    = cond_neg(b, sb);
    div_zero = (b == '0);
    div_ovf  = !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
  end

  // One radix-2 step each of shift-add multiply and restoring divide
  logic [XLEN:0]     mul_add;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    mul_add   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    mul_next  = {mul_add, acc[XLEN-1:1]};
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift - {1'b0, opnd};
    div_next  = div_ge ? {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1}
                       : {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

  // Final sign fix-up and half/quotient/remainder select
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_r;
  logic [XLEN-1:0]   quo_v;
  logic [XLEN-1:0]   rem_v;
  logic [XLEN-1:0]   m_res;

  always_comb begin
    prod  = cond_neg_wide(acc, neg_q);
    mul_r = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    quo_v = cond_neg(acc[XLEN-1:0], neg_q);
    rem_v = cond_neg(acc[2*XLEN-1:XLEN], neg_r);
    m_res = op_q[2] ? (op_q[1] ? rem_v : quo_v) : mul_r;
  end

  // Iteration datapath: loaded at accept, stepped while MUL/DIV
  always_ff @(posedge clk) begin
    if (accept && is_m) begin
      op_q <= op;
      opnd <= b_mag;
      if (is_div && div_zero) begin
        acc   <= {a, {XLEN{1'b1}}};
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end else if (is_div && div_ovf) begin
        acc   <= {{XLEN{1'b0}}, a};
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end else begin
        acc   <= {{XLEN{1'b0}}, a_mag};
        neg_q <= sa ^ sb;
        neg_r <= sa;
      end
    end else if (state == S_MUL) begin
      acc <= mul_next;
    end else if (state == S_DIV) begin
      acc <= div_next;
    end
  end

  // Control FSM and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      r         <= '0;
      cf        <= 1'b0;
      zf        <= 1'b0;
      vf        <= 1'b0;
      sf        <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (is_m) begin
              cnt <= '0;
              if (is_div && (div_zero || div_ovf)) state <= S_DONE;
              else if (is_div)                     state <= S_DIV;
              else                                 state <= S_MUL;
            end else begin
              r         <= base_r;
              cf        <= uses_adder && carry;
              zf        <= uses_adder ? (sum == '0) : (base_r == '0);
              vf        <= uses_adder && ovf;
              sf        <= uses_adder && sum[XLEN-1];
              out_valid <= 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          cnt <= cnt + SHW'(1);
          if (cnt == LAST_ITER) state <= S_DONE;
        end
        S_DONE: begin
          r         <= m_res;
          zf        <= (m_res == '0);
          cf        <= 1'b0;
          vf        <= 1'b0;
          sf        <= 1'b0;
          out_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_muldiv_unit.md
Name: alu_muldiv_unit

Overview:
Parametrised successor to the single-cycle execute ALU. It adds RV32M multiply/divide alongside the base arithmetic, logic, shift and compare operations.
- Base operations complete in one registered cycle.
- MUL/DIV run iteratively over multiple cycles behind a valid/ready handshake.
- Sits in the EX stage. The hazard unit stalls the pipeline while in_ready is low. The flush input kills an in-flight operation on branch mispredict.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
SHW, $clog2(XLEN), shift-amount width; derived, not overridden.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
flush  in  1  abort current/accepted op; no result produced
in_valid  in  1  operands and op valid this cycle
in_ready  out  1  unit can accept an op (state IDLE)
op  in  5  operation select; op[4]=0 base, op[4]=1 M-extension
a  in  XLEN  operand A (rs1)
b  in  XLEN  operand B (rs2/imm); shift amount = b[SHW-1:0]
out_valid  out  1  one-cycle pulse: r and flags valid
r  out  XLEN  result
cf  out  1  carry of add/sub
zf  out  1  zero flag
vf  out  1  signed overflow of add/sub
sf  out  1  sign of add/sub result

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; r=0; cf=zf=vf=sf=0; iteration counter=0.
- Accept: an op is accepted when in_valid && in_ready && !flush.
- Base op encodings (op[4]=0):
  - 0000 ADD, 0001 SUB, 0011 pass B.
  - 0100 OR, 0101 AND, 0111 XOR.
  - 1000 SLL, 1001 SRL, 1010 SRA.
  - 1101 SLT, 1111 SLTU.
  - Other codes give r=0.
- Add/sub and flags:
  - SUB, SLT and SLTU use a + ~b + 1.
  - cf = carry out of bit XLEN-1.
  - vf = a[MSB] ^ (~b)[MSB] ^ sum[MSB] ^ cf.
  - sf = sum[MSB]; zf = (sum==0).
  - SLT result = sf!=vf; SLTU result = ~cf.
- M op encodings (op[4]=1):
  - 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU.
  - 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
  - 11xxx are treated as base-op r=0 with 1-cycle latency.
- Base-op latency: registered at accept edge; out_valid=1 the next cycle. in_ready stays 1, so back-to-back accepts give back-to-back results.
- State machine: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL or DIV on accept of an M op; in_ready=0 from the next cycle.
  - MUL: radix-2 shift-add on magnitudes, 2*XLEN-bit product. Exactly XLEN iterations, then DONE.
  - Sign fix-up: negate the product if the operand signs differ (signed operands per op). MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - DIV: restoring division on magnitudes, XLEN iterations, then DONE. Quotient sign = sa^sb; remainder sign = sign of a.
  - DONE: r registered, out_valid=1 for one cycle, -> IDLE, in_ready=1.
  - Total M-op latency: out_valid asserted XLEN+1 cycles after the accept edge.
- Fast paths (skip iteration, IDLE -> DONE, 2-cycle latency):
  - Divisor zero: DIV/DIVU give all ones; REM/REMU give a.
  - Signed overflow (a = 100..0, b = all ones): DIV gives a; REM gives 0.
- Flags for M ops: zf=(r==0); cf=vf=sf=0.
- flush:
  - Any state -> IDLE next cycle, out_valid=0. A same-cycle in_valid is ignored.
  - flush in DONE suppresses out_valid.
- Operand capture: operands are latched at accept; changes on a/b/op during MUL/DIV have no effect.
- Reset mid-operation: identical to reset values next cycle; no out_valid.
- Outputs r and flags hold their last value while out_valid=0.

Test Plan:
1. ADD a=0x7FFFFFFF, b=1 -> next cycle out_valid=1, r=0x80000000, vf=1, sf=1, cf=0. Back-to-back SUB a=5, b=5 -> r=0, zf=1, cf=1.
2. SLT a=0xFFFFFFFF, b=1 -> r=1. SLTU with the same operands -> r=0. SRA a=0x80000000, b=31 -> r=0xFFFFFFFF.
3. MUL a=-3, b=7 -> out_valid exactly 33 cycles after accept, r=0xFFFFFFEB. MULHU a=b=0xFFFFFFFF -> r=0xFFFFFFFE. MULH with the same operands -> r=0. in_ready=0 throughout.
4. DIV a=-7, b=2 -> r=0xFFFFFFFD. REM with the same operands -> r=0xFFFFFFFF. DIVU a=7, b=0 -> 2 cycles, r=0xFFFFFFFF. DIV a=0x80000000, b=-1 -> r=0x80000000.
5. Start DIVU, assert flush at iteration 10 -> IDLE next cycle, in_ready=1, no out_valid. A following ADD 2+3 -> r=5.
6. Start MUL, assert rst at iteration 5 -> all outputs at reset values next cycle, in_ready=1. Repeat with XLEN=64: MUL latency 65 cycles.
